// File: rtl/button_pkg.sv
// Shared types and default timing for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_LONG_CYCLES     = 50000000;
  localparam int unsigned COUNT_W             = 8;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One key channel: synchronizer, debounce/hold FSM, event pulses, sticky flag and press counter.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_n,
  input  logic               clear,
  output logic               level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               event_flag,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [1:0]    sync;
  logic          key_low;
  btn_state_t    state, state_next, last_state;
  logic [DW-1:0] dcnt, dcnt_next;
  logic [HW-1:0] hold, hold_next;
  logic          long_fired, long_fired_next;
  logic          level_c, press_c, release_c, long_c;

  // Two-flop synchronizer; idles high (key released).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_n};
  end

  assign key_low = ~sync[1];

  // State register; last_state lets the output stage see transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RELEASED;
      last_state <= ST_RELEASED;
      dcnt       <= '0;
      hold       <= '0;
      long_fired <= 1'b0;
    end else begin
      state      <= state_next;
      last_state <= state;
      dcnt       <= dcnt_next;
      hold       <= hold_next;
      long_fired <= long_fired_next;
    end
  end

  always_comb begin
    state_next      = state;
    dcnt_next       = dcnt;
    hold_next       = hold;
    long_fired_next = long_fired;
    unique case (state)
      ST_RELEASED: begin
        hold_next       = '0;
        long_fired_next = 1'b0;
        if (key_low) begin
          state_next = ST_PRESS_CHK;
          dcnt_next  = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!key_low)              state_next = ST_RELEASED;
        else if (dcnt == DEB_LAST) state_next = ST_HELD;
        else                       dcnt_next  = dcnt + DW'(1);
      end
      ST_HELD: begin
        if (hold != HOLD_LAST) hold_next       = hold + HW'(1);
        else                   long_fired_next = 1'b1;
        if (!key_low) begin
          state_next = ST_REL_CHK;
          dcnt_next  = '0;
        end
      end
      ST_REL_CHK: begin
        if (key_low) begin
          state_next = ST_HELD;
        end else if (dcnt == DEB_LAST) begin
          state_next      = ST_RELEASED;
          hold_next       = '0;
          long_fired_next = 1'b0;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      default: state_next = ST_RELEASED;
    endcase
  end

  // Output decode: pulses come from completed transitions, so aborted checks emit nothing.
  always_comb begin
    level_c   = (state == ST_HELD) || (state == ST_REL_CHK);
    press_c   = (state == ST_HELD) && (last_state == ST_PRESS_CHK);
    release_c = (state == ST_RELEASED) && (last_state == ST_REL_CHK);
    long_c    = (state == ST_HELD) && (hold == HOLD_LAST) && !long_fired;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      level         <= level_c;
      press_pulse   <= press_c;
      release_pulse <= release_c;
      long_pulse    <= long_c;
    end
  end

  // Sticky flag and saturating count; a press wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_flag  <= 1'b0;
      press_count <= '0;
    end else if (press_pulse) begin
      event_flag <= 1'b1;
      if (clear)                 press_count <= COUNT_W'(1);
      else if (press_count != '1) press_count <= press_count + COUNT_W'(1);
    end else if (clear) begin
      event_flag  <= 1'b0;
      press_count <= '0;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced multi-key front end: one independent button_channel per board key.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         key_n,
  input  logic [N_BUTTONS-1:0]         clear,
  output logic [N_BUTTONS-1:0]         level,
  output logic [N_BUTTONS-1:0]         press_pulse,
  output logic [N_BUTTONS-1:0]         release_pulse,
  output logic [N_BUTTONS-1:0]         long_pulse,
  output logic [N_BUTTONS-1:0]         event_flag,
  output logic [COUNT_W*N_BUTTONS-1:0] press_count
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk          (CLOCK_50),
      .rst          (reset),
      .key_n        (key_n[i]),
      .clear        (clear[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .event_flag   (event_flag[i]),
      .press_count  (press_count[COUNT_W*i +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long-press times.
module tb_button_conditioner;

  localparam int unsigned NB  = 2;
  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   key_n, clear;
  logic [NB-1:0]   level, press_pulse, release_pulse, long_pulse, event_flag;
  logic [8*NB-1:0] press_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int seen_a, seen_b, seen_c;

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .key_n        (key_n),
    .clear        (clear),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .event_flag   (event_flag),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt(input int ch);
    return press_count[8*ch +: 8];
  endfunction

  initial begin
    reset = 1'b1;
    key_n = '1;
    clear = '0;
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 0);
    check("rst_flag", 32'(event_flag), 0);
    check("rst_count", 32'(press_count), 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Short glitch on ch0 must be rejected
    key_n[0] = 1'b0;
    repeat (3) tick();
    key_n[0] = 1'b1;
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_a += int'(press_pulse[0]);
      seen_b += int'(level[0]);
    end
    check("glitch_press", 32'(seen_a), 0);
    check("glitch_level", 32'(seen_b), 0);
    check("glitch_count", 32'(cnt(0)), 0);

    // Simultaneous press on both channels; clear[1] coincides with the pulse
    key_n = 2'b00;
    tick();
    repeat (6) tick();
    check("press_early", 32'(press_pulse), 0);
    tick();
    check("press_at7", 32'(press_pulse), 32'h3);
    check("press_level", 32'(level), 32'h3);
    clear[1] = 1'b1;
    tick();
    clear = '0;
    check("press_width", 32'(press_pulse), 0);
    check("flag_both", 32'(event_flag), 32'h3);
    check("count0_one", 32'(cnt(0)), 1);
    check("count1_clr_same", 32'(cnt(1)), 1);

    // Long hold gives exactly one long pulse
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_a += int'(long_pulse[0]);
      seen_b += int'(press_pulse[0]);
    end
    check("long_once", 32'(seen_a), 1);
    check("no_repress", 32'(seen_b), 0);

    // Short bounce high while held
    key_n[0] = 1'b1;
    repeat (2) tick();
    key_n[0] = 1'b0;
    seen_a = 0; seen_b = 0; seen_c = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_a += int'(release_pulse[0]);
      seen_b += int'(long_pulse[0]);
      seen_c += int'(level[0]);
    end
    check("bounce_release", 32'(seen_a), 0);
    check("bounce_long", 32'(seen_b), 0);
    check("bounce_level", 32'(seen_c), 10);

    // Qualified release on both channels
    key_n = 2'b11;
    tick();
    repeat (6) tick();
    check("release_early", 32'(release_pulse), 0);
    tick();
    check("release_at7", 32'(release_pulse), 32'h3);
    check("release_level", 32'(level), 0);
    tick();
    check("release_width", 32'(release_pulse), 0);

    // Clear ch0 alone
    clear[0] = 1'b1;
    tick();
    clear = '0;
    check("clear_flag", 32'(event_flag), 32'h2);
    check("clear_count0", 32'(cnt(0)), 0);
    check("clear_keeps1", 32'(cnt(1)), 1);

    // 256 presses on ch1 saturate the counter
    for (int i = 0; i < 256; i++) begin
      key_n[1] = 1'b0;
      repeat (9) tick();
      key_n[1] = 1'b1;
      repeat (9) tick();
      if (i == 252) check("count1_254", 32'(cnt(1)), 254);
    end
    check("count1_sat", 32'(cnt(1)), 255);
    check("flag1_set", 32'(event_flag[1]), 1);

    // Reset in the middle of a ch0 press qualification
    key_n[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("midrst_level", 32'(level), 0);
    check("midrst_count", 32'(press_count), 0);
    check("midrst_flag", 32'(event_flag), 0);
    repeat (2) tick();
    reset = 1'b0;
    key_n[0] = 1'b1;
    seen_a = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_a += int'(press_pulse[0]);
    end
    check("midrst_nopulse", 32'(seen_a), 0);
    key_n[0] = 1'b0;
    tick();
    repeat (6) tick();
    check("repress_early", 32'(press_pulse[0]), 0);
    tick();
    check("repress_at7", 32'(press_pulse[0]), 1);
    tick();
    check("repress_count", 32'(cnt(0)), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 2, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level qualification time (20 ms at 50 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, hold time for a long-press event (1 s at 50 MHz).
REQ-004 SHALL have port CLOCK_50  input  1  sole clock, all state rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port key_n  input  N_BUTTONS  raw, asynchronous, active-low board keys.
REQ-007 SHALL have port clear  input  N_BUTTONS  per-channel clear of sticky flag and press count, driven by the processor PIO.
REQ-008 SHALL have port level  output  N_BUTTONS  debounced active-high pressed level, feeding the system button PIO exports.
REQ-009 SHALL have port press_pulse  output  N_BUTTONS  one-cycle pulse on each qualified press.
REQ-010 SHALL have port release_pulse  output  N_BUTTONS  one-cycle pulse on each qualified release.
REQ-011 SHALL have port long_pulse  output  N_BUTTONS  one-cycle pulse when a press is held LONG_CYCLES.
REQ-012 SHALL have port event_flag  output  N_BUTTONS  sticky press-seen flag.
REQ-013 SHALL have port press_count  output  8*N_BUTTONS  per-channel press counter, channel i at bits [8i+7:8i].

Function
REQ-014 SHALL pass each key_n bit through a 2-flop synchronizer before any use.
REQ-015 SHALL run per channel the FSM RELEASED, PRESS_CHK, HELD, REL_CHK with one shared-width debounce counter and one hold counter.
REQ-016 RELEASED: synced key low -> PRESS_CHK, debounce counter 0; otherwise stay.
REQ-017 PRESS_CHK: synced key high -> RELEASED (glitch rejected, no output); counter reaching DEBOUNCE_CYCLES-1 while low -> HELD with press_pulse high that transition cycle; else increment.
REQ-018 HELD: level=1; hold counter increments, saturating at LONG_CYCLES-1; long_pulse asserts exactly once per press on reaching LONG_CYCLES-1; synced key high -> REL_CHK, debounce counter 0.
REQ-019 REL_CHK: synced key low -> HELD (hold counter not reset, no repeat long_pulse); counter reaching DEBOUNCE_CYCLES-1 while high -> RELEASED with release_pulse, hold counter cleared.
REQ-020 level SHALL be 1 in HELD and REL_CHK, 0 otherwise.
REQ-021 press_pulse SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the first rising edge sampling key_n low, when key_n stays low.
REQ-022 event_flag SHALL set on press_pulse, clear on clear; simultaneous set and clear -> flag 1.
REQ-023 press_count SHALL increment on press_pulse, saturate at 255, clear to 0 on clear; simultaneous -> count 1.
REQ-024 Pulses SHALL be registered, glitch-free, never longer than one cycle.
REQ-025 Channels SHALL be fully independent; simultaneous presses produce simultaneous pulses.

Reset
REQ-026 reset SHALL force synchronizer flops to 1, FSM to RELEASED, counters to 0, all outputs to 0, asynchronously.
REQ-027 reset asserted mid-press SHALL emit no pulse after deassertion until a full new DEBOUNCE_CYCLES qualification.

Structure
REQ-028 SHALL place the FSM state enum and default timing constants in package button_pkg.
REQ-029 SHALL implement one channel (synchronizer, FSM, counters, flag, count) as sub-module button_channel, instantiated N_BUTTONS times via generate.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-030 key_n[0] low held -> press_pulse[0] high exactly 7 cycles after first low sample, level[0]=1, press_count[0]=1, event_flag[0]=1.
REQ-031 key_n[0] low 3 cycles then high -> no pulse, level stays 0, count stays 0.
REQ-032 press held 20 cycles -> exactly one long_pulse[0]; bounce high 2 cycles during hold -> level stays 1, no release_pulse.
REQ-033 clear[1] in same cycle as press_pulse[1] -> event_flag[1]=1, press_count[1]=1; 256 presses -> count 255.
REQ-034 reset asserted during PRESS_CHK with key held low -> outputs 0 immediately; after release, press_pulse 7 cycles after first low sample.
